// File: rtl/issue_queue_ooo_if.sv
// Dispatch/wakeup/issue bundle for the collapsing OoO issue queue.
// slave = queue side, master = dispatch/execute side.
interface issue_queue_ooo_if #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_WB    = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    enq_valid;
  logic                    enq_ready;
  logic [PAYLOAD_W-1:0]    enq_payload;
  logic [TAG_W-1:0]        enq_src1_tag;
  logic                    enq_src1_rdy;
  logic [TAG_W-1:0]        enq_src2_tag;
  logic                    enq_src2_rdy;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic                    iss_valid;
  logic                    iss_ready;
  logic [PAYLOAD_W-1:0]    iss_payload;
  logic [TAG_W-1:0]        iss_src1_tag;
  logic [TAG_W-1:0]        iss_src2_tag;
  logic                    flush;
  logic [CNT_W-1:0]        count;

  modport master (
    output enq_valid, enq_payload,
    output enq_src1_tag, enq_src1_rdy,
    output enq_src2_tag, enq_src2_rdy,
    output wb_valid, wb_tag,
    output iss_ready, flush,
    input  enq_ready, iss_valid,
    input  iss_payload, iss_src1_tag,
    input  iss_src2_tag, count
  );

  modport slave (
    input  enq_valid, enq_payload,
    input  enq_src1_tag, enq_src1_rdy,
    input  enq_src2_tag, enq_src2_rdy,
    input  wb_valid, wb_tag,
    input  iss_ready, flush,
    output enq_ready, iss_valid,
    output iss_payload, iss_src1_tag,
    output iss_src2_tag, count
  );
endinterface

// File: rtl/issue_queue_ooo.sv
// Collapsing oldest-first OoO issue queue with CDB wakeup.
// Optional counters: define ISSUE_QUEUE_STATS_EN.
module issue_queue_ooo #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_WB    = 2
) (
  input  logic clk,
  input  logic rst,
  issue_queue_ooo_if.slave io
`ifdef ISSUE_QUEUE_STATS_EN
  ,
  output logic [31:0] stat_full_cycles,
  output logic [31:0] stat_issued
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic                 vld;
    logic [PAYLOAD_W-1:0] payload;
    logic [TAG_W-1:0]     tag1;
    logic                 rdy1;
    logic [TAG_W-1:0]     tag2;
    logic                 rdy2;
  } ent_t;

  ent_t             q     [DEPTH];
  ent_t             q_nxt [DEPTH];
  ent_t             wk    [DEPTH+1];
  ent_t             new_e;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] slot;
  logic [IDX_W-1:0] sel;
  logic             any_elig;
  logic             enq_fire;
  logic             iss_fire;

  function automatic logic wb_hit(
    input logic [TAG_W-1:0]        t,
    input logic [NUM_WB-1:0]       v,
    input logic [NUM_WB*TAG_W-1:0] tags
  );
    logic h;
    h = 1'b0;
    for (int k = 0; k < NUM_WB; k++)
      h = h | (v[k] && (tags[k*TAG_W +: TAG_W] == t));
    return h;
  endfunction

  // Descending scan leaves the lowest eligible index in sel.
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i].vld && q[i].rdy1 && q[i].rdy2) begin
        any_elig = 1'b1;
        sel      = IDX_W'(i);
      end
    end
  end

  assign io.enq_ready    = (cnt < CNT_W'(DEPTH));
  assign io.iss_valid    = any_elig && !io.flush;
  assign io.iss_payload  = q[sel].payload;
  assign io.iss_src1_tag = q[sel].tag1;
  assign io.iss_src2_tag = q[sel].tag2;
  assign io.count        = cnt;

  assign enq_fire = io.enq_valid && io.enq_ready && !io.flush;
  assign iss_fire = io.iss_valid && io.iss_ready;

  always_comb begin
    new_e.vld     = 1'b1;
    new_e.payload = io.enq_payload;
    new_e.tag1    = io.enq_src1_tag;
    new_e.tag2    = io.enq_src2_tag;
    new_e.rdy1    = io.enq_src1_rdy ||
                    wb_hit(io.enq_src1_tag, io.wb_valid, io.wb_tag);
    new_e.rdy2    = io.enq_src2_rdy ||
                    wb_hit(io.enq_src2_tag, io.wb_valid, io.wb_tag);

    for (int i = 0; i < DEPTH; i++) begin
      wk[i]      = q[i];
      wk[i].rdy1 = q[i].rdy1 | wb_hit(q[i].tag1, io.wb_valid, io.wb_tag);
      wk[i].rdy2 = q[i].rdy2 | wb_hit(q[i].tag2, io.wb_valid, io.wb_tag);
    end
    wk[DEPTH] = '0;

    // New entry lands just past the collapsed tail.
    slot = cnt - CNT_W'(iss_fire);
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_fire && (i >= int'(sel)))
        q_nxt[i] = wk[i+1];
      else
        q_nxt[i] = wk[i];
      if (enq_fire && (CNT_W'(i) == slot))
        q_nxt[i] = new_e;
      if (io.flush)
        q_nxt[i].vld = 1'b0;
    end

    if (io.flush)
      cnt_nxt = '0;
    else
      cnt_nxt = cnt + CNT_W'(enq_fire) - CNT_W'(iss_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else begin
      cnt <= cnt_nxt;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= q_nxt[i];
    end
  end

`ifdef ISSUE_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_full_cycles <= '0;
      stat_issued      <= '0;
    end else begin
      if ((cnt == CNT_W'(DEPTH)) && io.enq_valid &&
          (stat_full_cycles != '1))
        stat_full_cycles <= stat_full_cycles + 32'd1;
      if (iss_fire && (stat_issued != '1))
        stat_issued <= stat_issued + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_ooo.sv
// Directed bench for issue_queue_ooo (DEPTH=8, TAG_W=6, NUM_WB=2).
// Expected values are hand-computed per step.
module tb_issue_queue_ooo;
  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  issue_queue_ooo_if #(
    .DEPTH(8), .TAG_W(6), .PAYLOAD_W(64), .NUM_WB(2)
  ) io ();

`ifdef ISSUE_QUEUE_STATS_EN
  logic [31:0] stat_full_cycles;
  logic [31:0] stat_issued;
`endif

  issue_queue_ooo #(
    .DEPTH(8), .TAG_W(6), .PAYLOAD_W(64), .NUM_WB(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
`ifdef ISSUE_QUEUE_STATS_EN
    ,
    .stat_full_cycles(stat_full_cycles),
    .stat_issued(stat_issued)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [63:0] p,
                         input logic [5:0] t1, input logic r1,
                         input logic [5:0] t2, input logic r2);
    io.enq_valid    = v;
    io.enq_payload  = p;
    io.enq_src1_tag = t1;
    io.enq_src1_rdy = r1;
    io.enq_src2_tag = t2;
    io.enq_src2_rdy = r2;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    set_enq(1'b0, 64'h0, 6'd0, 1'b0, 6'd0, 1'b0);
    io.wb_valid  = 2'b00;
    io.wb_tag    = '0;
    io.iss_ready = 1'b0;
    io.flush     = 1'b0;
    tick();
    tick();
    chk("rst_count", 64'(io.count), 64'd0);
    chk("rst_iss_valid", 64'(io.iss_valid), 64'd0);
    chk("rst_enq_ready", 64'(io.enq_ready), 64'd1);
    rst = 1'b0;

    // single ready instruction flows straight through
    set_enq(1'b1, 64'hA1, 6'd1, 1'b1, 6'd2, 1'b1);
    tick();
    io.enq_valid = 1'b0;
    #1;
    chk("t1_count", 64'(io.count), 64'd1);
    chk("t1_iss_valid", 64'(io.iss_valid), 64'd1);
    chk("t1_payload", io.iss_payload, 64'hA1);
    io.iss_ready = 1'b1;
    tick();
    io.iss_ready = 1'b0;
    #1;
    chk("t1_count_after", 64'(io.count), 64'd0);
    chk("t1_iss_valid_after", 64'(io.iss_valid), 64'd0);

    // younger ready B issues before older waiting A
    set_enq(1'b1, 64'hA2, 6'd5, 1'b0, 6'd7, 1'b1);
    tick();
    set_enq(1'b1, 64'hB2, 6'd3, 1'b1, 6'd4, 1'b1);
    tick();
    io.enq_valid = 1'b0;
    #1;
    chk("t2_count", 64'(io.count), 64'd2);
    chk("t2_b_first", io.iss_payload, 64'hB2);
    io.iss_ready = 1'b1;
    tick();
    io.iss_ready = 1'b0;
    io.wb_valid  = 2'b01;
    io.wb_tag    = {6'd0, 6'd6};
    #1;
    chk("t2_count_b_gone", 64'(io.count), 64'd1);
    chk("t2_a_wait", 64'(io.iss_valid), 64'd0);
    tick();
    chk("t2_stray_tag", 64'(io.iss_valid), 64'd0);
    io.wb_tag = {6'd0, 6'd5};
    #1;
    chk("t2_wake_cycle_t", 64'(io.iss_valid), 64'd0);
    tick();
    io.wb_valid = 2'b00;
    #1;
    chk("t2_wake_t1", 64'(io.iss_valid), 64'd1);
    chk("t2_a_payload", io.iss_payload, 64'hA2);
    chk("t2_a_src1", 64'(io.iss_src1_tag), 64'd5);
    io.iss_ready = 1'b1;
    tick();
    io.iss_ready = 1'b0;

    // wakeup on the enqueue cycle itself
    set_enq(1'b1, 64'hC3, 6'd3, 1'b1, 6'd9, 1'b0);
    io.wb_valid = 2'b10;
    io.wb_tag   = {6'd9, 6'd0};
    tick();
    io.enq_valid = 1'b0;
    io.wb_valid  = 2'b00;
    #1;
    chk("t3_iss_valid", 64'(io.iss_valid), 64'd1);
    chk("t3_payload", io.iss_payload, 64'hC3);
    chk("t3_src2", 64'(io.iss_src2_tag), 64'd9);
    io.iss_ready = 1'b1;
    tick();
    io.iss_ready = 1'b0;
    #1;
    chk("t3_count", 64'(io.count), 64'd0);

    // fill to DEPTH with stalled execute stage
    for (int i = 0; i < 8; i++) begin
      set_enq(1'b1, 64'h100 + 64'(i), 6'd1, 1'b1, 6'd1, 1'b1);
      tick();
    end
    set_enq(1'b1, 64'h1FF, 6'd1, 1'b1, 6'd1, 1'b1);
    #1;
    chk("t4_full_count", 64'(io.count), 64'd8);
    chk("t4_enq_ready", 64'(io.enq_ready), 64'd0);
    chk("t4_head_held", io.iss_payload, 64'h100);
    tick();
    io.enq_valid = 1'b0;
    #1;
    chk("t4_no_overfill", 64'(io.count), 64'd8);
    chk("t4_head_still", io.iss_payload, 64'h100);
    io.iss_ready = 1'b1;
    tick();
    io.iss_ready = 1'b0;
    #1;
    chk("t4_count7", 64'(io.count), 64'd7);
    chk("t4_entry1", io.iss_payload, 64'h101);

    // enqueue + issue at count 7, then drain in order
    set_enq(1'b1, 64'h200, 6'd1, 1'b1, 6'd1, 1'b1);
    io.iss_ready = 1'b1;
    #1;
    chk("t5_sel", io.iss_payload, 64'h101);
    tick();
    io.enq_valid = 1'b0;
    #1;
    chk("t5_count_stays", 64'(io.count), 64'd7);
    for (int i = 0; i < 6; i++) begin
      chk("t5_drain", io.iss_payload, 64'h102 + 64'(i));
      tick();
    end
    chk("t5_new_last", io.iss_payload, 64'h200);
    chk("t5_count1", 64'(io.count), 64'd1);
    tick();
    io.iss_ready = 1'b0;
    #1;
    chk("t5_empty", 64'(io.count), 64'd0);

`ifdef ISSUE_QUEUE_STATS_EN
    chk("st_issued", 64'(stat_issued), 64'd13);
    chk("st_full", 64'(stat_full_cycles), 64'd1);
`endif

    // flush beats enqueue and issue
    for (int i = 0; i < 5; i++) begin
      set_enq(1'b1, 64'h300 + 64'(i), 6'd1, 1'b1, 6'd1, 1'b1);
      tick();
    end
    chk("t6_count5", 64'(io.count), 64'd5);
    set_enq(1'b1, 64'h3FF, 6'd1, 1'b1, 6'd1, 1'b1);
    io.iss_ready = 1'b1;
    io.flush     = 1'b1;
    #1;
    chk("t6_iss_valid_flush", 64'(io.iss_valid), 64'd0);
    tick();
    io.flush     = 1'b0;
    io.enq_valid = 1'b0;
    io.iss_ready = 1'b0;
    #1;
    chk("t6_count0", 64'(io.count), 64'd0);
    chk("t6_iss_valid", 64'(io.iss_valid), 64'd0);
`ifdef ISSUE_QUEUE_STATS_EN
    chk("st_issued_flush", 64'(stat_issued), 64'd13);
`endif

    // async reset mid-operation
    set_enq(1'b1, 64'h400, 6'd1, 1'b1, 6'd1, 1'b1);
    tick();
    tick();
    io.enq_valid = 1'b0;
    #1;
    chk("t7_count2", 64'(io.count), 64'd2);
    rst = 1'b1;
    #1;
    chk("t7_async_count", 64'(io.count), 64'd0);
    chk("t7_async_iss", 64'(io.iss_valid), 64'd0);
    chk("t7_async_rdy", 64'(io.enq_ready), 64'd1);
    #1;
    rst = 1'b0;
    set_enq(1'b1, 64'h500, 6'd1, 1'b1, 6'd1, 1'b1);
    tick();
    io.enq_valid = 1'b0;
    #1;
    chk("t7_first_enq", 64'(io.count), 64'd1);
    chk("t7_payload", io.iss_payload, 64'h500);
`ifdef ISSUE_QUEUE_STATS_EN
    chk("st_issued_rst", 64'(stat_issued), 64'd0);
    chk("st_full_rst", 64'(stat_full_cycles), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
